sub_4bit_result_collector: RTL

Downstream stage for the 4-bit subtractor: captures each `diff`/`overflow` result through a valid/ready handshake. Results are buffered in a small FIFO toward the consumer. The block also keeps running statistics: a saturating signed sum of differences and a count of overflow events. It decouples the combinational subtractor from a consumer that may stall.

---
 rtl/sub_4bit_result_collector.sv | 87 ++++++++
 1 files changed

// File: rtl/sub_4bit_result_collector.sv
// rtl/sub_4bit_result_collector.sv - buffers 4-bit subtractor results in a FIFO and keeps sum/overflow statistics
module sub_4bit_result_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [3:0]               in_diff,
  input  logic                     in_ovf,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_diff,
  output logic                     out_ovf,
  input  logic                     clear,
  output logic [7:0]               sum,
  output logic [CNT_W-1:0]         ovf_count,
  output logic                     ovf_sticky,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          accept;
  logic          pop;
  logic [8:0]    sum_ext;
  logic [7:0]    sum_next;

  // Handshake flags come only from registered occupancy, so there is no comb path from out_ready to in_ready.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_diff  = mem[rd_ptr][3:0];
  assign out_ovf   = mem[rd_ptr][4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= {in_ovf, in_diff};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // 9-bit add exposes signed overflow as a mismatch between the top two bits.
  always_comb begin
    sum_ext  = {sum[7], sum} + {{5{in_diff[3]}}, in_diff};
    sum_next = sum_ext[7:0];
    if (sum_ext[8] != sum_ext[7]) sum_next = sum_ext[8] ? 8'h80 : 8'h7f;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum        <= '0;
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end else if (clear) begin
      sum        <= '0;
      ovf_count  <= '0;
      ovf_sticky <= 1'b0;
    end else if (accept) begin
      sum <= sum_next;
      if (in_ovf) begin
        if (!(&ovf_count)) ovf_count <= ovf_count + CNT_W'(1);
        ovf_sticky <= 1'b1;
      end
    end
  end

endmodule
